keypad_entry: RTL

Sits directly downstream of the PMOD keypad scanner and consumes its 4-bit key code and one-clock key_valid pulse. Collects up to DIGITS decimal digits into a BCD entry buffer for the seven-segment display and supports backspace, clear and enter keys. On enter, a sequential BCD-to-binary converter produces the binary value. The value is then offered to the next stage over a valid/ready handshake.

---
 rtl/keypad_entry.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// keypad_entry
//   Collects decimal key presses from the keypad scanner into a BCD entry
//   buffer, supports backspace/clear/enter, converts the entry to binary
//   one nibble per cycle and offers the result on a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   key, key_valid    scanner key code and its one-clock strobe
//   entry             BCD buffer, newest digit in nibble 0
//   digit_count       digits currently held (0..DIGITS)
//   value             binary result of the last conversion
//   value_valid       result offered, held until value_ready
//   value_ready       downstream accepts value
//   busy              converting or holding a result
//   err               one-clock pulse per rejected/dropped key
module keypad_entry #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14,
  parameter int CW     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key,
  input  logic                key_valid,
  output logic [4*DIGITS-1:0] entry,
  output logic [CW-1:0]       digit_count,
  output logic [WIDTH-1:0]    value,
  output logic                value_valid,
  input  logic                value_ready,
  output logic                busy,
  output logic                err
);

  localparam int EW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

  state_t           state_q;
  logic [EW-1:0]    entry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] value_q;
  logic             vv_q;
  logic             busy_q;
  logic             err_q;

  logic [3:0]       nib;
  logic [WIDTH-1:0] acc_d;

  // Current nibble under conversion and acc*10 + nibble (shift-add, wraps at WIDTH)
  always_comb begin
    nib   = entry_q[{idx_q, 2'b00} +: 4];
    acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      entry_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (key_valid) begin
            case (key)
              4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
              4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                if (cnt_q != CW'(DIGITS)) begin
                  entry_q <= (entry_q << 4) | EW'(key);
                  cnt_q   <= cnt_q + CW'(1);
                end else begin
                  err_q <= 1'b1;
                end
              end
              4'hA: begin
                if (cnt_q == '0) begin
                  err_q <= 1'b1;
                end else begin
                  state_q <= CONVERT;
                  busy_q  <= 1'b1;
                  acc_q   <= '0;
                  idx_q   <= IW'(DIGITS - 1);
                end
              end
              4'hB: begin
                if (cnt_q != '0) begin
                  entry_q <= entry_q >> 4;
                  cnt_q   <= cnt_q - CW'(1);
                end
              end
              4'hC: begin
                entry_q <= '0;
                cnt_q   <= '0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        CONVERT: begin
          // Keys are not buffered while busy
          err_q <= key_valid;
          acc_q <= acc_d;
          if (idx_q == '0) begin
            state_q <= HOLD;
            value_q <= acc_d;
            vv_q    <= 1'b1;
            entry_q <= '0;
            cnt_q   <= '0;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        HOLD: begin
          err_q <= key_valid;
          if (value_ready) begin
            vv_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ENTRY;
          end
        end
        default: begin
          state_q <= ENTRY;
          busy_q  <= 1'b0;
          vv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign entry       = entry_q;
  assign digit_count = cnt_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
